// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
//
// A multi-port register file with an embedded program counter, a per-register
// busy scoreboard and a sequential clear engine.
//
// Register index PC_ADDR holds the PC.
// - The write ports cannot modify it.
// - It changes only through:
//   - pc_ld (load a value),
//   - pc_inc (increment, wrapping modulo 2**DATA_W),
//   - the clear sequence,
//   - reset.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   rd_addr1/2 -> rd_data1/2   combinational read ports (optional forwarding)
//   rd_busy1/2                 scoreboard busy bit of the addressed register
//   wr_en0/addr0/data0         write port 0
//   wr_en1/addr1/data1         write port 1 (wins over port 0)
//   rsv_en, rsv_addr           mark a register busy (pending producer)
//   pc_ld, pc_in, pc_inc       PC load / increment requests (load wins)
//   pc_out                     current PC contents
//   clr_req                    start clearing the whole file, one entry per cycle
//   clr_busy                   high while the clear sequence runs
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int PC_ADDR = (1 << ADDR_W) - 1,
    parameter int BYPASS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en0,
    input  logic [ADDR_W-1:0] wr_addr0,
    input  logic [DATA_W-1:0] wr_data0,
    input  logic              wr_en1,
    input  logic [ADDR_W-1:0] wr_addr1,
    input  logic [DATA_W-1:0] wr_data1,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              pc_ld,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              pc_inc,
    output logic [DATA_W-1:0] pc_out,
    input  logic              clr_req,
    output logic              clr_busy
);

    localparam int                NREG   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(PC_ADDR);
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(NREG - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]   regs_q [NREG];
    logic [DATA_W-1:0]   regs_d [NREG];
    logic [NREG-1:0]     busy_q, busy_d;

    // Next-state logic for the file, scoreboard, PC and clear engine.
    always_comb begin
        regs_d  = regs_q;
        busy_d  = busy_q;
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                // Port 1 is applied after port 0 so it wins on equal addresses.
                if (wr_en0 && wr_addr0 != PC_IDX) begin
                    regs_d[wr_addr0] = wr_data0;
                    busy_d[wr_addr0] = 1'b0;
                end
                if (wr_en1 && wr_addr1 != PC_IDX) begin
                    regs_d[wr_addr1] = wr_data1;
                    busy_d[wr_addr1] = 1'b0;
                end
                // Reserve applied last: a same-edge write leaves the entry busy.
                if (rsv_en && rsv_addr != PC_IDX) begin
                    busy_d[rsv_addr] = 1'b1;
                end
                if (pc_ld) begin
                    regs_d[PC_IDX] = pc_in;
                end else if (pc_inc) begin
                    regs_d[PC_IDX] = regs_q[PC_IDX] + DATA_W'(1);
                end
                if (clr_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                regs_d[idx_q] = '0;
                busy_d[idx_q] = 1'b0;
                idx_d         = idx_q + ADDR_W'(1);   // wraps to 0 after LAST
                if (idx_q == LAST) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q  <= '0;
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            regs_q  <= regs_d;
            busy_q  <= busy_d;
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Read ports. Forwarding only applies while writes can actually land
    // (IDLE) and never to the PC, which the write ports cannot touch.
    for (genvar gi = 0; gi < 2; gi++) begin : gen_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] val;
        assign addr = (gi == 0) ? rd_addr1 : rd_addr2;
        always_comb begin
            val = regs_q[addr];
            if (BYPASS != 0 && state_q == IDLE && addr != PC_IDX) begin
                if (wr_en1 && wr_addr1 == addr) begin
                    val = wr_data1;
                end else if (wr_en0 && wr_addr0 == addr) begin
                    val = wr_data0;
                end
            end
        end
    end

    assign rd_data1 = gen_rd[0].val;
    assign rd_data2 = gen_rd[1].val;
    assign rd_busy1 = busy_q[rd_addr1];
    assign rd_busy2 = busy_q[rd_addr2];
    assign pc_out   = regs_q[PC_IDX];
    assign clr_busy = (state_q == CLEAR);

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
//
// Directed scenarios for writes, forwarding, the scoreboard, the PC, clear and
// asynchronous reset, followed by a randomized run. Every cycle all outputs
// are compared with a reference model of the register file kept here.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int NR = 8;
    localparam int PC = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rd_addr1, rd_addr2;
    logic [DW-1:0] rd_data1, rd_data2;
    logic          rd_busy1, rd_busy2;
    logic          wr_en0, wr_en1;
    logic [AW-1:0] wr_addr0, wr_addr1;
    logic [DW-1:0] wr_data0, wr_data1;
    logic          rsv_en;
    logic [AW-1:0] rsv_addr;
    logic          pc_ld, pc_inc;
    logic [DW-1:0] pc_in;
    logic [DW-1:0] pc_out;
    logic          clr_req;
    logic          clr_busy;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .PC_ADDR(PC), .BYPASS(1)) dut (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .pc_ld(pc_ld), .pc_in(pc_in), .pc_inc(pc_inc), .pc_out(pc_out),
        .clr_req(clr_req), .clr_busy(clr_busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain array of values (entry 7 is the PC), busy flags
    // and a count of clear cycles still to run.
    logic [DW-1:0] m_val [NR];
    bit            m_busy [NR];
    int            m_clr_left;
    int            m_clr_pos;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h @%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_val[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_clr_left = 0;
        m_clr_pos  = 0;
    endtask

    function automatic logic [DW-1:0] exp_rd(input int a);
        if (m_clr_left == 0 && a != PC) begin
            if (wr_en1 && int'(wr_addr1) == a) return wr_data1;
            if (wr_en0 && int'(wr_addr0) == a) return wr_data0;
        end
        return m_val[a];
    endfunction

    // Apply the rules for one rising edge using the inputs currently driven.
    task automatic model_edge();
        if (m_clr_left > 0) begin
            m_val[m_clr_pos]  = '0;
            m_busy[m_clr_pos] = 1'b0;
            m_clr_pos++;
            m_clr_left--;
        end else begin
            if (wr_en0 && int'(wr_addr0) != PC) begin
                m_val[wr_addr0] = wr_data0; m_busy[wr_addr0] = 1'b0;
            end
            if (wr_en1 && int'(wr_addr1) != PC) begin
                m_val[wr_addr1] = wr_data1; m_busy[wr_addr1] = 1'b0;
            end
            if (rsv_en && int'(rsv_addr) != PC) m_busy[rsv_addr] = 1'b1;
            if (pc_ld)       m_val[PC] = pc_in;
            else if (pc_inc) m_val[PC] = DW'((int'(m_val[PC]) + 1) % 65536);
            if (clr_req) begin
                m_clr_left = NR;
                m_clr_pos  = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("rd_data1", rd_data1, exp_rd(int'(rd_addr1)));
        chk("rd_data2", rd_data2, exp_rd(int'(rd_addr2)));
        chk("rd_busy1", rd_busy1, m_busy[rd_addr1]);
        chk("rd_busy2", rd_busy2, m_busy[rd_addr2]);
        chk("pc_out",   pc_out,   m_val[PC]);
        chk("clr_busy", clr_busy, m_clr_left > 0);
    endtask

    // One cycle: check outputs on the falling edge, advance the model on the
    // rising edge, return 1 time unit later so new inputs can be driven.
    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_in();
        wr_en0 = 0; wr_en1 = 0; rsv_en = 0; pc_ld = 0; pc_inc = 0; clr_req = 0;
        wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0;
        rsv_addr = '0; pc_in = '0;
    endtask

    task automatic fill_all();
        for (int i = 0; i < NR - 1; i++) begin
            idle_in();
            wr_en0 = 1; wr_addr0 = AW'(i); wr_data0 = DW'(16'h1000 + i);
            rsv_en = (i % 2) == 1; rsv_addr = AW'(i);
            step();
        end
        idle_in(); pc_ld = 1; pc_in = 16'h0BAD;
        step();
        idle_in();
    endtask

    initial begin
        idle_in();
        rd_addr1 = '0; rd_addr2 = '0;
        rst = 1'b1;
        model_reset();
        #12;
        rst = 1'b0;
        #1;
        check_all();
        chk("reset_pc", pc_out, 16'h0000);

        // Port 0 write, read back next cycle.
        wr_en0 = 1; wr_addr0 = 3'd2; wr_data0 = 16'hA5A5;
        step();
        idle_in(); rd_addr1 = 3'd2; #1;
        chk("r2_data", rd_data1, 16'hA5A5);
        chk("r2_busy", rd_busy1, 1'b0);

        // Dual write to one address, forwarded and stored.
        wr_en0 = 1; wr_addr0 = 3'd3; wr_data0 = 16'h1111;
        wr_en1 = 1; wr_addr1 = 3'd3; wr_data1 = 16'h2222;
        rd_addr1 = 3'd3; #1;
        chk("byp_r3", rd_data1, 16'h2222);
        step();
        idle_in(); #1;
        chk("r3_stored", rd_data1, 16'h2222);

        // Scoreboard.
        rsv_en = 1; rsv_addr = 3'd4; rd_addr1 = 3'd4;
        step();
        idle_in(); #1;
        chk("r4_busy_set", rd_busy1, 1'b1);
        rsv_en = 1; rsv_addr = 3'd4; wr_en0 = 1; wr_addr0 = 3'd4; wr_data0 = 16'h00FF;
        step();
        idle_in(); #1;
        chk("r4_rsv_wr_data", rd_data1, 16'h00FF);
        chk("r4_rsv_wr_busy", rd_busy1, 1'b1);
        wr_en1 = 1; wr_addr1 = 3'd4; wr_data1 = 16'h1234;
        step();
        idle_in(); #1;
        chk("r4_busy_clr", rd_busy1, 1'b0);
        rsv_en = 1; rsv_addr = 3'd7;
        step();
        idle_in(); rd_addr2 = 3'd7; #1;
        chk("pc_busy", rd_busy2, 1'b0);

        // PC behaviour.
        pc_ld = 1; pc_in = 16'hFFFF;
        step();
        idle_in(); pc_inc = 1;
        step();
        idle_in(); #1;
        chk("pc_wrap", pc_out, 16'h0000);
        pc_ld = 1; pc_in = 16'h0040; pc_inc = 1;
        step();
        idle_in(); wr_en1 = 1; wr_addr1 = 3'd7; wr_data1 = 16'hBEEF; #1;
        chk("pc_ld_wins", pc_out, 16'h0040);
        chk("pc_no_byp", rd_data2, 16'h0040);
        step();
        idle_in(); #1;
        chk("pc_wr_ignored", pc_out, 16'h0040);

        // Full clear with junk requests during the sequence.
        fill_all();
        clr_req = 1;
        step();
        for (int k = 0; k < NR; k++) begin
            wr_en0 = 1; wr_addr0 = AW'(k); wr_data0 = 16'hDEAD;
            wr_en1 = 1; wr_addr1 = AW'(7 - k); wr_data1 = 16'hCAFE;
            rsv_en = 1; rsv_addr = AW'(k); pc_inc = 1; clr_req = 1;
            rd_addr1 = AW'(k); #1;
            chk("clr_busy_on", clr_busy, 1'b1);
            step();
        end
        idle_in(); #1;
        chk("clr_busy_off", clr_busy, 1'b0);
        chk("clr_pc", pc_out, 16'h0000);
        for (int a = 0; a < NR; a++) begin
            rd_addr1 = AW'(a); #1;
            chk("clr_data", rd_data1, 16'h0000);
            chk("clr_bsy", rd_busy1, 1'b0);
        end

        // Asynchronous reset in the middle of a clear.
        fill_all();
        clr_req = 1;
        step();
        idle_in();
        step(); step();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_pc", pc_out, 16'h0000);
        chk("arst_clr", clr_busy, 1'b0);
        for (int a = 0; a < NR; a++) begin
            rd_addr1 = AW'(a); #0;
            chk("arst_data", rd_data1, 16'h0000);
            chk("arst_busy", rd_busy1, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_release", clr_busy, 1'b0);
        @(posedge clk);
        #1;

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            wr_en0   = ($urandom_range(0, 1) == 1);
            wr_addr0 = AW'($urandom_range(0, 7));
            wr_data0 = DW'($urandom);
            wr_en1   = ($urandom_range(0, 1) == 1);
            wr_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr0 : AW'($urandom_range(0, 7));
            wr_data1 = DW'($urandom);
            rsv_en   = ($urandom_range(0, 2) == 0);
            rsv_addr = AW'($urandom_range(0, 7));
            pc_ld    = ($urandom_range(0, 9) == 0);
            pc_in    = ($urandom_range(0, 3) == 0) ? 16'hFFFF : DW'($urandom);
            pc_inc   = ($urandom_range(0, 1) == 1);
            clr_req  = ($urandom_range(0, 39) == 0);
            rd_addr1 = ($urandom_range(0, 1) == 1) ? wr_addr1 : AW'($urandom_range(0, 7));
            rd_addr2 = ($urandom_range(0, 1) == 1) ? wr_addr0 : AW'($urandom_range(0, 7));
            step();
        end
        idle_in();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 16, register and PC width in bits.
REQ-002 Parameter ADDR_W, default 3, register address width; NREG = 2**ADDR_W registers.
REQ-003 Parameter PC_ADDR, default NREG-1, index of the dedicated PC register.
REQ-004 Parameter BYPASS, default 1, 1 enables write-to-read forwarding, 0 disables it.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 rd_addr1, rd_addr2  in  ADDR_W  read-port addresses.
REQ-008 rd_data1, rd_data2  out  DATA_W  read data, combinational.
REQ-009 rd_busy1, rd_busy2  out  1  scoreboard busy bit of the addressed register, combinational.
REQ-010 wr_en0, wr_addr0, wr_data0  in  1/ADDR_W/DATA_W  write port 0.
REQ-011 wr_en1, wr_addr1, wr_data1  in  1/ADDR_W/DATA_W  write port 1; higher priority than port 0.
REQ-012 rsv_en, rsv_addr  in  1/ADDR_W  reserve request; marks a register busy (pending producer).
REQ-013 pc_ld, pc_in  in  1/DATA_W  PC load request and value.
REQ-014 pc_inc  in  1  PC increment request.
REQ-015 pc_out  out  DATA_W  current PC register contents.
REQ-016 clr_req  in  1  start sequential clear of the whole file.
REQ-017 clr_busy  out  1  high while the clear sequence runs.

Function
REQ-018 Writes: wr_enN=1 writes wr_dataN to wr_addrN at the edge; both ports to the same address: port 1 data stored.
REQ-019 Writes addressed to PC_ADDR via wr ports are ignored; the PC changes only through pc_ld, pc_inc, clear, reset.
REQ-020 PC update per edge: pc_ld -> pc_in; else pc_inc -> PC+1 modulo 2**DATA_W (all-ones wraps to 0); else hold; pc_ld beats pc_inc.
REQ-021 Reads: rd_dataN = stored contents of rd_addrN; rd_addrN=PC_ADDR returns stored PC.
REQ-022 BYPASS=1: reading an address (not PC_ADDR) under an active write this cycle returns the write data, port 1 over port 0; BYPASS=0 returns pre-edge contents.
REQ-023 Scoreboard: one busy bit per register; rsv_en sets busy[rsv_addr] at the edge; any accepted write to an address clears its busy bit.
REQ-024 Same-edge reserve and write to one address: data written, busy ends 1 (reserve wins).
REQ-025 rsv_addr=PC_ADDR is ignored; busy[PC_ADDR] is always 0.
REQ-026 Clear FSM states IDLE and CLEAR; IDLE + clr_req -> CLEAR with index 0; clr_busy = (state==CLEAR).
REQ-027 In CLEAR, each edge zeroes register[index] (PC when index=PC_ADDR) and its busy bit, then index+1; after index NREG-1 -> IDLE; sequence lasts exactly NREG cycles.
REQ-028 In CLEAR, wr_en0/1, rsv_en, pc_ld, pc_inc and clr_req are ignored; reads remain live (bypass disabled).
REQ-029 After return to IDLE, port requests are accepted on the next edge.

Reset
REQ-030 rst=1 immediately forces all registers, PC, busy bits to 0, FSM to IDLE, index to 0, clr_busy to 0, independent of clk.
REQ-031 rst asserted mid-CLEAR aborts the sequence; after release the block is in IDLE with all state zero.

Verification
REQ-032 Reset, write r2=16'hA5A5 via port 0, next cycle rd_addr1=2 -> rd_data1=16'hA5A5, rd_busy1=0.
REQ-033 Same edge wr0 r3=16'h1111, wr1 r3=16'h2222, BYPASS=1 read r3 that cycle -> 16'h2222; after edge stored 16'h2222.
REQ-034 rsv r4 -> rd_busy=1 next cycle; rsv r4 plus write r4=16'h00FF same edge -> data 16'h00FF, busy stays 1; later write-only r4 -> busy 0.
REQ-035 PC=16'hFFFF, pc_inc -> pc_out=16'h0000; pc_ld=1 pc_in=16'h0040 with pc_inc=1 -> 16'h0040; wr_en1 to PC_ADDR -> PC unchanged.
REQ-036 Fill all registers nonzero, pulse clr_req -> clr_busy=1 for 8 cycles (ADDR_W=3), writes ignored meanwhile, then all reads and pc_out = 0, busy bits 0.
REQ-037 Assert rst asynchronously during CLEAR cycle 3 -> all outputs 0 before next clk edge, clr_busy=0 after release.
